// File: rtl/frame_buffer_writer_if.sv
// rtl/frame_buffer_writer_if.sv - pixel stream and burst write port bundle for frame_buffer_writer
// Ports carried:
//   s_axis_tdata/tvalid/tlast/tuser/tready : pixel stream (tuser = start of frame, tlast = end of line)
//   wr_cmd_valid/ready, wr_addr, wr_len     : burst command (wr_len = beats-1)
//   wr_data/strb/valid/ready                : burst beat data
//   wr_resp_valid                           : burst completion
// Modports: master = frame writer side, slave = stream source / memory side.
interface frame_buffer_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BPB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tuser;
    logic                  s_axis_tready;

    logic                  wr_cmd_valid;
    logic                  wr_cmd_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_len;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BPB-1:0]        wr_strb;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_resp_valid;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output wr_cmd_valid, wr_addr, wr_len, wr_data, wr_strb, wr_valid,
        input  wr_cmd_ready, wr_ready, wr_resp_valid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  wr_cmd_valid, wr_addr, wr_len, wr_data, wr_strb, wr_valid,
        output wr_cmd_ready, wr_ready, wr_resp_valid
    );
endinterface

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - pixel stream to rotating frame buffers, split into bursts
// Ports:
//   clk, rst_n (async, active-low)
//   frame_width/frame_height : frame geometry, sampled on the SOF beat
//   bus (frame_buffer_writer_if.master) : pixel stream in, burst write port out
//   frame_done      : one-cycle pulse when a frame is fully written
//   frame_base_addr : base of the last completed buffer
//   frame_err       : sticky line-length/SOF error flag for the current frame
//   frame_cnt/err_cnt : status counters, present only when FBW_STATUS_EN is defined
module frame_buffer_writer #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_BUFFERS = 3,
    parameter int                    MAX_BURST   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    frame_buffer_writer_if.master bus,
    output logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] frame_base_addr,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt
);
    localparam int BPB = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, CMD, DATA, PAD, DROP, RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic                  run_q, run_d;
    logic [15:0]           w_q, w_d, h_q, h_d;
    logic [15:0]           line_q, line_d, pix_q, pix_d;
    logic [7:0]            len_q, len_d, beat_q, beat_d;
    logic [3:0]            buf_idx_q, buf_idx_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] frame_base_addr_q, frame_base_addr_d;
    logic                  err_q, err_d;
    logic                  first_q, first_d;
    logic                  line_end_q, line_end_d;
    logic                  resp_pend_q, resp_pend_d;

    logic                  sof_ok;
    logic [31:0]           base_prod;
    logic [31:0]           offset;
    logic [15:0]           rem;
    logic [7:0]            burst_len;
    logic                  last_pix;
    logic                  last_beat;

    assign sof_ok    = bus.s_axis_tvalid & bus.s_axis_tuser & (frame_width != 16'd0) & (frame_height != 16'd0);
    assign base_prod = 32'(buf_idx_q) * 32'(frame_width) * 32'(frame_height) * 32'(BPB);
    assign offset    = (32'(line_q) * 32'(w_q) + 32'(pix_q)) * 32'(BPB);
    assign rem       = w_q - pix_q;
    assign burst_len = ({16'd0, rem} > 32'(MAX_BURST)) ? 8'(MAX_BURST - 1) : 8'(rem - 16'd1);
    assign last_pix  = (pix_q == w_q - 16'd1);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        state_d           = state_q;
        run_d             = 1'b1;
        w_d               = w_q;
        h_d               = h_q;
        line_d            = line_q;
        pix_d             = pix_q;
        len_d             = len_q;
        beat_d            = beat_q;
        buf_idx_d         = buf_idx_q;
        base_d            = base_q;
        frame_base_addr_d = frame_base_addr_q;
        err_d             = err_q;
        first_d           = first_q;
        line_end_d        = line_end_q;
        resp_pend_d       = resp_pend_q;
        bus.s_axis_tready = 1'b0;
        bus.wr_cmd_valid  = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_len        = 8'd0;
        bus.wr_data       = '0;
        bus.wr_strb       = '0;
        bus.wr_valid      = 1'b0;
        frame_done        = 1'b0;

        // A response can overtake the tail of the burst; remember it for RESP.
        if (bus.wr_resp_valid && (state_q == DATA || state_q == PAD || state_q == DROP))
            resp_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                // The SOF beat is left on the bus so DATA writes it as pixel 0.
                bus.s_axis_tready = run_q & ~sof_ok;
                if (run_q && sof_ok) begin
                    w_d         = frame_width;
                    h_d         = frame_height;
                    line_d      = 16'd0;
                    pix_d       = 16'd0;
                    base_d      = BASE_ADDR + ADDR_WIDTH'(base_prod);
                    err_d       = 1'b0;
                    first_d     = 1'b1;
                    line_end_d  = 1'b0;
                    resp_pend_d = 1'b0;
                    state_d     = CMD;
                end
            end
            CMD: begin
                bus.wr_cmd_valid = 1'b1;
                bus.wr_addr      = base_q + ADDR_WIDTH'(offset);
                bus.wr_len       = burst_len;
                if (bus.wr_cmd_ready) begin
                    len_d   = burst_len;
                    beat_d  = 8'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                bus.wr_valid      = bus.s_axis_tvalid;
                bus.wr_data       = bus.s_axis_tdata;
                bus.wr_strb       = '1;
                bus.s_axis_tready = bus.wr_ready;
                if (bus.s_axis_tvalid && bus.wr_ready) begin
                    pix_d   = pix_q + 16'd1;
                    beat_d  = beat_q + 8'd1;
                    first_d = 1'b0;
                    if (bus.s_axis_tuser && !first_q)
                        err_d = 1'b1;
                    if (bus.s_axis_tlast && !last_pix) begin
                        err_d      = 1'b1;
                        line_end_d = 1'b1;
                        state_d    = last_beat ? RESP : PAD;
                    end else if (last_pix && !bus.s_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = DROP;
                    end else if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            PAD: begin
                // Fill the already-committed burst with masked beats.
                bus.wr_valid = 1'b1;
                if (bus.wr_ready) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat)
                        state_d = RESP;
                end
            end
            DROP: begin
                bus.s_axis_tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast)
                    state_d = RESP;
            end
            RESP: begin
                if (bus.wr_resp_valid || resp_pend_q) begin
                    resp_pend_d = 1'b0;
                    if (!line_end_q && pix_q != w_q) begin
                        state_d = CMD;
                    end else begin
                        pix_d      = 16'd0;
                        line_end_d = 1'b0;
                        line_d     = line_q + 16'd1;
                        if (line_q + 16'd1 < h_q) begin
                            state_d = CMD;
                        end else begin
                            frame_base_addr_d = base_q;
                            state_d           = DONE;
                        end
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                err_d      = 1'b0;
                buf_idx_d  = (buf_idx_q == 4'(NUM_BUFFERS - 1)) ? 4'd0 : buf_idx_q + 4'd1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            run_q             <= 1'b0;
            w_q               <= 16'd0;
            h_q               <= 16'd0;
            line_q            <= 16'd0;
            pix_q             <= 16'd0;
            len_q             <= 8'd0;
            beat_q            <= 8'd0;
            buf_idx_q         <= 4'd0;
            base_q            <= '0;
            frame_base_addr_q <= '0;
            err_q             <= 1'b0;
            first_q           <= 1'b0;
            line_end_q        <= 1'b0;
            resp_pend_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            run_q             <= run_d;
            w_q               <= w_d;
            h_q               <= h_d;
            line_q            <= line_d;
            pix_q             <= pix_d;
            len_q             <= len_d;
            beat_q            <= beat_d;
            buf_idx_q         <= buf_idx_d;
            base_q            <= base_d;
            frame_base_addr_q <= frame_base_addr_d;
            err_q             <= err_d;
            first_q           <= first_d;
            line_end_q        <= line_end_d;
            resp_pend_q       <= resp_pend_d;
        end
    end

    assign frame_base_addr = frame_base_addr_q;
    assign frame_err       = err_q;

`ifdef FBW_STATUS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic        zero_sof;

    assign zero_sof = (state_q == IDLE) & run_q & bus.s_axis_tvalid & bus.s_axis_tuser & ~sof_ok;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (state_q == DONE)
            frame_cnt_d = frame_cnt_q + 16'd1;
        if (((state_q == DONE && err_q) || zero_sof) && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = 16'd0;
    assign err_cnt   = 16'd0;
`endif
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - self-checking bench for frame_buffer_writer
module tb_frame_buffer_writer;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BPB = DW / 8;
    localparam int NB  = 3;
    localparam int MB  = 16;

    typedef struct {
        int          w;
        int          h;
        int          kind;      // 0 normal, 1 early tlast, 2 overlong line, 3 stray tuser
        int          bad_line;
        int          nb;        // beats sent on the bad line (kinds 1 and 2)
        int          stall;
        logic [31:0] exp_base;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] frame_width = 16'd0;
    logic [15:0] frame_height = 16'd0;
    logic        frame_done;
    logic [31:0] frame_base_addr;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    frame_buffer_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    frame_buffer_writer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BUFFERS(NB), .MAX_BURST(MB), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_width(frame_width), .frame_height(frame_height),
        .bus(bus), .frame_done(frame_done), .frame_base_addr(frame_base_addr),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    int checks = 0;
    int errors = 0;

    // memory side observer
    logic [31:0] mem [int];
    int b_addr[$];
    int b_len[$];
    int cur_word = 0, cur_beat = 0, cur_len = -1;
    int wcount = 0, strb0 = 0, bad_beats = 0, done_cnt = 0, last_beats = 0;

    // responder controls, written only by the main sequence
    bit stall_mode = 1'b0;
    int resp_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int f, input int l, input int p);
        return {8'(f + 1), 8'(l), 16'(p)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_len  = -1;
            cur_beat = 0;
        end else begin
            if (bus.wr_cmd_valid && bus.wr_cmd_ready) begin
                b_addr.push_back(int'(bus.wr_addr));
                b_len.push_back(int'(bus.wr_len));
                cur_word = int'(bus.wr_addr) / BPB;
                cur_beat = 0;
                cur_len  = int'(bus.wr_len);
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (cur_beat > cur_len) begin
                    bad_beats++;
                end else begin
                    if (bus.wr_strb == 4'hF) begin
                        mem[cur_word + cur_beat] = bus.wr_data;
                        wcount++;
                    end else if (bus.wr_strb == 4'h0) begin
                        strb0++;
                    end else begin
                        bad_beats++;
                    end
                    if (cur_beat == cur_len)
                        last_beats++;
                end
                cur_beat++;
            end
            if (frame_done)
                done_cnt++;
        end
    end

    initial begin
        int served;
        int resp_cnt;
        served = 0;
        resp_cnt = -1;
        bus.wr_cmd_ready  = 1'b0;
        bus.wr_ready      = 1'b0;
        bus.wr_resp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                served = last_beats;
                resp_cnt = -1;
                bus.wr_cmd_ready  = 1'b0;
                bus.wr_ready      = 1'b0;
                bus.wr_resp_valid = 1'b0;
            end else begin
                bus.wr_cmd_ready  = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.wr_ready      = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.wr_resp_valid = 1'b0;
                if (last_beats != served) begin
                    served = last_beats;
                    resp_cnt = resp_delay;
                end
                if (resp_cnt == 0) begin
                    bus.wr_resp_valid = 1'b1;
                    resp_cnt = -1;
                end else if (resp_cnt > 0) begin
                    resp_cnt--;
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input bit last, input bit user);
        bit hs;
        hs = 1'b0;
        if (stall_mode && $urandom_range(0, 3) == 0) begin
            bus.s_axis_tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tuser  = user;
        bus.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 500 && !hs; i++) begin
            @(negedge clk);
            hs = bus.s_axis_tready;
            @(posedge clk);
            #1;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout actual=no_handshake required=handshake data=0x%0h", d);
        end
    endtask

    task automatic run_frame(input int f, input int w, input int h, input int kind, input int bad_line,
                             input int nb, output logic [31:0] base_seen, output bit err_seen);
        int  n;
        bit  done_ok;
        frame_width  = 16'(w);
        frame_height = 16'(h);
        for (int l = 0; l < h; l++) begin
            n = (l == bad_line && (kind == 1 || kind == 2)) ? nb : w;
            for (int p = 0; p < n; p++) begin
                send_beat(pat(f, l, p), p == n - 1,
                          (l == 0 && p == 0) || (kind == 3 && l == bad_line && p == 1));
                if (l == 0 && p == 0) begin
                    frame_width  = 16'hFFFF;
                    frame_height = 16'hFFFF;
                end
            end
        end
        done_ok   = 1'b0;
        base_seen = 32'hDEAD_BEEF;
        err_seen  = 1'b0;
        for (int i = 0; i < 400 && !done_ok; i++) begin
            @(negedge clk);
            if (frame_done) begin
                done_ok   = 1'b1;
                base_seen = frame_base_addr;
                err_seen  = frame_err;
            end
        end
        @(posedge clk);
        #1;
        if (!done_ok) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout frame=%0d actual=none required=pulse", f);
        end
    endtask

    task automatic check_frame(input string tag, input int f, input int w, input int h, input int kind,
                               input int bad_line, input int nb, input logic [31:0] base,
                               input int b0, input int w0, input int s0, input int e0);
        int nexp, bad, exp_s0, exp_w, memerr, endp, pix, len, word;
        nexp = 0; bad = 0; exp_s0 = 0; exp_w = 0; memerr = 0;
        for (int l = 0; l < h; l++) begin
            endp = (l == bad_line && kind == 1) ? nb - 1 : w - 1;
            pix = 0;
            do begin
                len = (w - pix > MB) ? MB : w - pix;
                if (b0 + nexp >= b_addr.size())
                    bad++;
                else if (b_addr[b0 + nexp] != int'(base) + (l * w + pix) * BPB || b_len[b0 + nexp] != len - 1)
                    bad++;
                nexp++;
                pix += len;
            end while (pix <= endp);
            exp_s0 += pix - 1 - endp;
            for (int p = 0; p <= endp; p++) begin
                word = int'(base) / BPB + l * w + p;
                exp_w++;
                if (!mem.exists(word))
                    memerr++;
                else if (mem[word] !== pat(f, l, p))
                    memerr++;
            end
        end
        check({tag, "_burst_count"}, 32'(b_addr.size() - b0), 32'(nexp));
        check({tag, "_burst_list_bad"}, 32'(bad), 32'd0);
        check({tag, "_words_written"}, 32'(wcount - w0), 32'(exp_w));
        check({tag, "_pad_beats"}, 32'(strb0 - s0), 32'(exp_s0));
        check({tag, "_mem_mismatch"}, 32'(memerr), 32'd0);
        check({tag, "_stray_beats"}, 32'(bad_beats - e0), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        logic [31:0] base_seen;
        bit          err_seen;
        int          b0, w0, s0, e0, d0;
        int          a_exp[4];
        int          l_exp[4];

        vecs[0] = '{4, 1, 0, -1, 0, 0, 32'h00, 1'b0};
        vecs[1] = '{4, 1, 0, -1, 0, 0, 32'h10, 1'b0};
        vecs[2] = '{4, 1, 0, -1, 0, 0, 32'h20, 1'b0};
        vecs[3] = '{4, 1, 0, -1, 0, 0, 32'h00, 1'b0};
        vecs[4] = '{8, 2, 1, 0, 3, 0, 32'h40, 1'b1};
        vecs[5] = '{8, 2, 2, 0, 10, 0, 32'h80, 1'b1};
        vecs[6] = '{6, 3, 0, -1, 0, 1, 32'h00, 1'b0};
        vecs[7] = '{40, 1, 0, -1, 0, 1, 32'hA0, 1'b0};
        vecs[8] = '{5, 2, 3, 0, 0, 0, 32'h50, 1'b1};
        vecs[9] = '{3, 1, 2, 0, 4, 1, 32'h00, 1'b1};
        a_exp = '{32'h0, 32'h40, 32'h50, 32'h90};
        l_exp = '{15, 3, 15, 3};

        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;

        // reset state
        #23;
        check("rst_tready", 32'(bus.s_axis_tready), 32'd0);
        check("rst_cmd_valid", 32'(bus.wr_cmd_valid), 32'd0);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_base", frame_base_addr, 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tready", 32'(bus.s_axis_tready), 32'd1);

        // 20x2 frame, two bursts per line
        b0 = b_addr.size(); w0 = wcount; s0 = strb0; e0 = bad_beats;
        run_frame(1, 20, 2, 0, -1, 0, base_seen, err_seen);
        check("a_base", base_seen, 32'h0);
        check("a_err", 32'(err_seen), 32'd0);
        check("a_burst_count", 32'(b_addr.size() - b0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (b0 + i < b_addr.size()) begin
                check($sformatf("a_burst%0d_addr", i), 32'(b_addr[b0 + i]), 32'(a_exp[i]));
                check($sformatf("a_burst%0d_len", i), 32'(b_len[b0 + i]), 32'(l_exp[i]));
            end
        end
        check_frame("a", 1, 20, 2, 0, -1, 0, 32'h0, b0, w0, s0, e0);

        // reset in the middle of a burst of buffer 1
        frame_width  = 16'd8;
        frame_height = 16'd1;
        send_beat(pat(99, 0, 0), 1'b0, 1'b1);
        send_beat(pat(99, 0, 1), 1'b0, 1'b0);
        send_beat(pat(99, 0, 2), 1'b0, 1'b0);
        bus.s_axis_tvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("midrst_wr_strb", 32'(bus.wr_strb), 32'd0);
        check("midrst_tready", 32'(bus.s_axis_tready), 32'd0);
        check("midrst_cmd_valid", 32'(bus.wr_cmd_valid), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // table of frames: rotation, line-length errors, stalls
        for (int i = 0; i < 10; i++) begin
            stall_mode = vecs[i].stall != 0;
            resp_delay = (vecs[i].stall != 0) ? 5 : 0;
            b0 = b_addr.size(); w0 = wcount; s0 = strb0; e0 = bad_beats;
            run_frame(10 + i, vecs[i].w, vecs[i].h, vecs[i].kind, vecs[i].bad_line, vecs[i].nb,
                      base_seen, err_seen);
            check($sformatf("v%0d_base", i), base_seen, vecs[i].exp_base);
            check($sformatf("v%0d_err", i), 32'(err_seen), 32'(vecs[i].exp_err));
            check_frame($sformatf("v%0d", i), 10 + i, vecs[i].w, vecs[i].h, vecs[i].kind,
                        vecs[i].bad_line, vecs[i].nb, vecs[i].exp_base, b0, w0, s0, e0);
        end
        stall_mode = 1'b0;
        resp_delay = 0;

        // stray beat and zero-size SOF are both discarded in IDLE
        b0 = b_addr.size();
        d0 = done_cnt;
        frame_width  = 16'd0;
        frame_height = 16'd5;
        send_beat(32'h1234_5678, 1'b0, 1'b0);
        send_beat(32'h8765_4321, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("zero_sof_bursts", 32'(b_addr.size() - b0), 32'd0);
        check("zero_sof_no_done", 32'(done_cnt - d0), 32'd0);

        check("total_frame_done", 32'(done_cnt), 32'd11);
`ifdef FBW_STATUS_EN
        check("frame_cnt", 32'(frame_cnt), 32'd11);
        check("err_cnt", 32'(err_cnt), 32'd5);
`else
        check("frame_cnt", 32'(frame_cnt), 32'd0);
        check("err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
